param_data_path: RTL and testbench
==================================

// Module: param_data_path
// PURPOSE
//  Parametrised successor of the 8-bit accumulator datapath: width-generic PC/MAR/IR, NUM_REGS-entry register file
//  replacing fixed A/B, built-in ALU with NZVC flags, and a hardware stack pointer with push/pop addressing.
//  Sits between the control FSM (all *_Sel/*_Load/*_Inc strobes) and the unified memory (address/to_memory/from_memory).
// PARAMETERS
//  DATA_W    8     data path, register file, bus, IR and ALU width
//  ADDR_W    8     PC, MAR, SP and address width; must be <= DATA_W
//  NUM_REGS  4     general registers R0..R(NUM_REGS-1); power of two, >= 2
//  SP_INIT   8'hFF reset value of SP (empty stack; stack grows downward)
// PORTS
//  Clk          in   1        rising-edge clock
//  Reset        in   1        synchronous, active-high
//  from_memory  in   DATA_W   memory read data
//  Bus1_Sel     in   2        00 PC (zero-extended), 01 R[Src_A], 10 R[Src_B], 11 SP (zero-extended)
//  Bus2_Sel     in   2        00 ALU result, 01 Bus1, 10 from_memory, 11 all zeros
//  Src_A,Src_B  in   log2(NUM_REGS)  register-file read indices (ALU operands A/B)
//  Dst          in   log2(NUM_REGS)  register-file write index
//  ALU_Sel      in   3        000 ADD,001 SUB(A-B),010 AND,011 OR,100 XOR,101 INC A,110 DEC A,111 NOT A
//  Addr_Sel     in   1        0 address=MAR, 1 address=SP
//  IR_Load,MAR_Load,PC_Load,Reg_Load,CCR_Load  in 1  load strobes (from Bus2 / ALU flags)
//  PC_Inc,SP_Inc,SP_Dec,Err_Clr  in 1  increment/decrement strobes; sticky-error clear
//  address      out  ADDR_W   memory address (combinational mux)
//  to_memory    out  DATA_W   write data = Bus1 (combinational)
//  IR_out       out  DATA_W   instruction register
//  CCR_Result   out  4        registered flags {N,Z,V,C}
//  SP_out       out  ADDR_W   current stack pointer
//  Stack_Err    out  1        sticky stack overflow/underflow
// BEHAVIOUR
//  Reset (sync, on Clk edge with Reset=1): PC=MAR=IR=all R=0, CCR=0, SP=SP_INIT, Stack_Err=0; overrides all strobes.
//  Buses, address, to_memory, ALU result/flags are combinational from current register state; all registers update on
//   rising Clk only. Bus1 sel of PC/SP zero-extends to DATA_W; PC/MAR/SP load take Bus2[ADDR_W-1:0].
//  Register file: 1 write port (Reg_Load writes Bus2 to R[Dst]), 2 async read ports; write visible next cycle
//   (no write-through). Src_A==Dst read returns old value during the write cycle.
//  PC: PC_Load has priority over PC_Inc; PC_Inc wraps all-ones -> 0 without error.
//  ALU, all DATA_W bits, modulo 2^DATA_W: N=result MSB; Z=(result==0); ADD: C=carry out, V=signed overflow;
//   SUB: C=borrow (A<B unsigned), V=signed overflow; INC/DEC: C,V as ADD/SUB with operand 1; logic ops/NOT: V=C=0.
//  CCR_Load latches ALU flags regardless of Bus2_Sel; CCR unchanged otherwise.
//  SP: SP_Dec -> SP-1, SP_Inc -> SP+1, both wrap modulo 2^ADDR_W; SP_Inc and SP_Dec together: SP unchanged, no error.
//   PC_Load/MAR_Load do not touch SP; SP loadable only via Bus2 when Bus1_Sel... not at all: SP changes only by Inc/Dec/Reset.
//  Push = control asserts SP_Dec (cycle 1) then Addr_Sel=1 + write (cycle 2); pop = read at Addr_Sel=1 then SP_Inc.
//  Stack_Err: set on SP_Dec alone with SP==0 (overflow) or SP_Inc alone with SP==SP_INIT (underflow); stays set until
//   Reset or Err_Clr; Err_Clr same cycle as a new error: error wins (stays 1). SP still wraps on error.
//  Illegal parameter sets (ADDR_W>DATA_W, NUM_REGS not power of two) fail elaboration.
// TESTING (DATA_W=8, ADDR_W=8, NUM_REGS=4 unless stated)
//  Reset mid-run: R1=8'h55, PC=8'h10, SP=8'hFD, assert Reset 1 cycle -> all regs 0, SP=8'hFF, CCR=0, Stack_Err=0.
//  ALU flags: R0=8'h7F,R1=8'h01, ADD, CCR_Load -> result 8'h80, CCR=4'b1010; SUB 8'h00-8'h01 -> 8'hFF, CCR=4'b1001.
//  PC priority/wrap: PC=8'hFF, PC_Inc -> 8'h00; PC_Load+PC_Inc with Bus2=from_memory=8'h3C -> PC=8'h3C.
//  Push/pop: R2=8'hA5; SP_Dec, then Addr_Sel=1,Bus1_Sel=01,Src_A=2 -> address=8'hFE, to_memory=8'hA5; SP_Inc -> 8'hFF.
//  Stack errors: SP_Inc at SP=8'hFF -> SP=8'h00, Stack_Err=1 held; Err_Clr -> 0; SP_Inc+SP_Dec at SP=8'hFF -> no change, no error.
//  Parametrised: DATA_W=16,ADDR_W=12,NUM_REGS=8: R7=16'hFFFF INC -> 16'h0000, CCR=4'b0101; PC on Bus1 reads 16'h0xxx.

Source files
------------

// File: rtl/param_data_path.sv
// Width-generic CPU datapath: PC/MAR/IR, NUM_REGS-entry register file, NZVC ALU and a
// downward-growing hardware stack pointer with sticky overflow/underflow detection.
module param_data_path #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       NUM_REGS = 4,
   parameter logic [ADDR_W-1:0] SP_INIT  = ADDR_W'(8'hFF),
   localparam int unsigned      RIDX_W   = $clog2(NUM_REGS)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] from_memory,
   input  logic [1:0]        Bus1_Sel,
   input  logic [1:0]        Bus2_Sel,
   input  logic [RIDX_W-1:0] Src_A,
   input  logic [RIDX_W-1:0] Src_B,
   input  logic [RIDX_W-1:0] Dst,
   input  logic [2:0]        ALU_Sel,
   input  logic              Addr_Sel,
   input  logic              IR_Load,
   input  logic              MAR_Load,
   input  logic              PC_Load,
   input  logic              Reg_Load,
   input  logic              CCR_Load,
   input  logic              PC_Inc,
   input  logic              SP_Inc,
   input  logic              SP_Dec,
   input  logic              Err_Clr,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] to_memory,
   output logic [DATA_W-1:0] IR_out,
   output logic [3:0]        CCR_Result,
   output logic [ADDR_W-1:0] SP_out,
   output logic              Stack_Err
);

   // Reject parameter sets the datapath cannot represent.
   generate
      if (ADDR_W > DATA_W) begin : g_bad_addr_w
         $error("param_data_path: ADDR_W must not exceed DATA_W");
      end
      if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
         $error("param_data_path: NUM_REGS must be a power of two and at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      BUS1_PC = 2'b00,
      BUS1_RA = 2'b01,
      BUS1_RB = 2'b10,
      BUS1_SP = 2'b11
   } bus1_sel_e;

   typedef enum logic [1:0] {
      BUS2_ALU  = 2'b00,
      BUS2_BUS1 = 2'b01,
      BUS2_MEM  = 2'b10,
      BUS2_ZERO = 2'b11
   } bus2_sel_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_INC = 3'b101,
      ALU_DEC = 3'b110,
      ALU_NOT = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [ADDR_W-1:0] sp_q, sp_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   flags_t            ccr_q, ccr_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] rf_d [NUM_REGS];

   logic [DATA_W-1:0] bus1;
   logic [DATA_W-1:0] bus2;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_opnd;
   logic [DATA_W:0]   alu_sum;
   logic [DATA_W:0]   alu_diff;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              alu_ovf;
   flags_t            alu_flags;
   logic              err_set;

   // ALU: INC/DEC reuse the adder/subtractor with a constant-one second operand.
   always_comb begin
      alu_a     = rf_q[Src_A];
      alu_b     = rf_q[Src_B];
      alu_opnd  = ((alu_op_e'(ALU_Sel) == ALU_INC) || (alu_op_e'(ALU_Sel) == ALU_DEC))
                  ? DATA_W'(1) : alu_b;
      alu_sum   = {1'b0, alu_a} + {1'b0, alu_opnd};
      alu_diff  = {1'b0, alu_a} - {1'b0, alu_opnd};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (alu_op_e'(ALU_Sel))
         ALU_ADD, ALU_INC: begin
            alu_res   = alu_sum[DATA_W-1:0];
            alu_carry = alu_sum[DATA_W];
            alu_ovf   = (alu_a[DATA_W-1] == alu_opnd[DATA_W-1]) &&
                        (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
         end
         ALU_SUB, ALU_DEC: begin
            alu_res   = alu_diff[DATA_W-1:0];
            alu_carry = alu_diff[DATA_W];
            alu_ovf   = (alu_a[DATA_W-1] != alu_opnd[DATA_W-1]) &&
                        (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
         end
         ALU_AND: alu_res = alu_a & alu_b;
         ALU_OR:  alu_res = alu_a | alu_b;
         ALU_XOR: alu_res = alu_a ^ alu_b;
         ALU_NOT: alu_res = ~alu_a;
         default: alu_res = '0;
      endcase
      alu_flags.n = alu_res[DATA_W-1];
      alu_flags.z = (alu_res == '0);
      alu_flags.v = alu_ovf;
      alu_flags.c = alu_carry;
   end

   // Bus1 feeds the memory write port; PC and SP are zero-extended onto it.
   always_comb begin
      bus1 = '0;
      case (bus1_sel_e'(Bus1_Sel))
         BUS1_PC: bus1 = DATA_W'(pc_q);
         BUS1_RA: bus1 = rf_q[Src_A];
         BUS1_RB: bus1 = rf_q[Src_B];
         BUS1_SP: bus1 = DATA_W'(sp_q);
         default: bus1 = '0;
      endcase
   end

   always_comb begin
      bus2 = '0;
      case (bus2_sel_e'(Bus2_Sel))
         BUS2_ALU:  bus2 = alu_res;
         BUS2_BUS1: bus2 = bus1;
         BUS2_MEM:  bus2 = from_memory;
         BUS2_ZERO: bus2 = '0;
         default:   bus2 = '0;
      endcase
   end

   assign address   = Addr_Sel ? sp_q : mar_q;
   assign to_memory = bus1;

   // Next-state for every architectural register.
   always_comb begin
      pc_d  = pc_q;
      mar_d = mar_q;
      ir_d  = ir_q;
      ccr_d = ccr_q;
      sp_d  = sp_q;
      rf_d  = rf_q;

      if (PC_Load) begin
         pc_d = ADDR_W'(bus2);
      end else if (PC_Inc) begin
         pc_d = pc_q + ADDR_W'(1);
      end
      if (MAR_Load) mar_d = ADDR_W'(bus2);
      if (IR_Load)  ir_d  = bus2;
      if (CCR_Load) ccr_d = alu_flags;
      if (Reg_Load) rf_d[Dst] = bus2;

      // Simultaneous inc/dec cancel out and are never an error.
      case ({SP_Inc, SP_Dec})
         2'b10:   sp_d = sp_q + ADDR_W'(1);
         2'b01:   sp_d = sp_q - ADDR_W'(1);
         default: sp_d = sp_q;
      endcase

      err_set = (SP_Dec && !SP_Inc && (sp_q == '0)) ||
                (SP_Inc && !SP_Dec && (sp_q == SP_INIT));
      err_d   = err_set || (err_q && !Err_Clr);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q  <= '0;
         mar_q <= '0;
         ir_q  <= '0;
         ccr_q <= '0;
         sp_q  <= SP_INIT;
         err_q <= 1'b0;
         rf_q  <= '{default: '0};
      end else begin
         pc_q  <= pc_d;
         mar_q <= mar_d;
         ir_q  <= ir_d;
         ccr_q <= ccr_d;
         sp_q  <= sp_d;
         err_q <= err_d;
         rf_q  <= rf_d;
      end
   end

   assign IR_out     = ir_q;
   assign CCR_Result = ccr_q;
   assign SP_out     = sp_q;
   assign Stack_Err  = err_q;

endmodule

// File: tb/tb_param_data_path.sv
// Directed bench for param_data_path: default 8/8/4 instance plus a 16/12/8 instance
// sharing clock, reset and control strobes.
module tb_param_data_path;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [7:0]  from_memory;
   logic [15:0] from_memory_w;
   logic [1:0]  Bus1_Sel, Bus2_Sel;
   logic [1:0]  Src_A, Src_B, Dst;
   logic [2:0]  src_a_w, src_b_w, dst_w;
   logic [2:0]  ALU_Sel;
   logic        Addr_Sel, IR_Load, MAR_Load, PC_Load, Reg_Load, CCR_Load;
   logic        PC_Inc, SP_Inc, SP_Dec, Err_Clr;

   logic [7:0]  address, to_memory, IR_out, SP_out;
   logic [3:0]  CCR_Result;
   logic        Stack_Err;

   logic [11:0] address_w, sp_out_w;
   logic [15:0] to_memory_w, ir_out_w;
   logic [3:0]  ccr_w;
   logic        stack_err_w;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   param_data_path u_dut (
      .Clk(Clk), .Reset(Reset), .from_memory(from_memory),
      .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
      .Src_A(Src_A), .Src_B(Src_B), .Dst(Dst), .ALU_Sel(ALU_Sel), .Addr_Sel(Addr_Sel),
      .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .Reg_Load(Reg_Load),
      .CCR_Load(CCR_Load), .PC_Inc(PC_Inc), .SP_Inc(SP_Inc), .SP_Dec(SP_Dec),
      .Err_Clr(Err_Clr), .address(address), .to_memory(to_memory), .IR_out(IR_out),
      .CCR_Result(CCR_Result), .SP_out(SP_out), .Stack_Err(Stack_Err)
   );

   param_data_path #(.DATA_W(16), .ADDR_W(12), .NUM_REGS(8)) u_dut_w (
      .Clk(Clk), .Reset(Reset), .from_memory(from_memory_w),
      .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
      .Src_A(src_a_w), .Src_B(src_b_w), .Dst(dst_w), .ALU_Sel(ALU_Sel), .Addr_Sel(Addr_Sel),
      .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .Reg_Load(Reg_Load),
      .CCR_Load(CCR_Load), .PC_Inc(PC_Inc), .SP_Inc(SP_Inc), .SP_Dec(SP_Dec),
      .Err_Clr(Err_Clr), .address(address_w), .to_memory(to_memory_w), .IR_out(ir_out_w),
      .CCR_Result(ccr_w), .SP_out(sp_out_w), .Stack_Err(stack_err_w)
   );

   task automatic idle();
      from_memory = '0; from_memory_w = '0;
      Bus1_Sel = 2'b00; Bus2_Sel = 2'b00;
      Src_A = '0; Src_B = '0; Dst = '0;
      src_a_w = '0; src_b_w = '0; dst_w = '0;
      ALU_Sel = 3'b000; Addr_Sel = 1'b0;
      IR_Load = 1'b0; MAR_Load = 1'b0; PC_Load = 1'b0; Reg_Load = 1'b0; CCR_Load = 1'b0;
      PC_Inc = 1'b0; SP_Inc = 1'b0; SP_Dec = 1'b0; Err_Clr = 1'b0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      idle(); Reset = 1'b1; tick(); Reset = 1'b0;
   endtask

   task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
      idle(); Bus2_Sel = 2'b10; from_memory = val; Dst = idx; Reg_Load = 1'b1;
      tick(); idle();
   endtask

   task automatic load_reg_w(input logic [2:0] idx, input logic [15:0] val);
      idle(); Bus2_Sel = 2'b10; from_memory_w = val; dst_w = idx; Reg_Load = 1'b1;
      tick(); idle();
   endtask

   task automatic test_reset();
      // Reset must override simultaneous strobes.
      idle(); Reset = 1'b1; PC_Inc = 1'b1; SP_Dec = 1'b1; tick(); Reset = 1'b0; idle(); #1;
      checks++; if (IR_out !== 8'h00) begin errors++; $display("FAIL reset_ir: got %h want 00", IR_out); end
      checks++; if (CCR_Result !== 4'h0) begin errors++; $display("FAIL reset_ccr: got %b want 0000", CCR_Result); end
      checks++; if (SP_out !== 8'hFF) begin errors++; $display("FAIL reset_sp: got %h want FF", SP_out); end
      checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", Stack_Err); end
      checks++; if (address !== 8'h00) begin errors++; $display("FAIL reset_mar: got %h want 00", address); end
      checks++; if (to_memory !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", to_memory); end

      // Dirty state, then reset mid-run.
      load_reg(2'd1, 8'h55);
      Bus2_Sel = 2'b10; from_memory = 8'h10; PC_Load = 1'b1; tick(); idle();
      SP_Inc = 1'b1; tick(); idle();
      SP_Dec = 1'b1; tick(); tick(); tick(); idle();
      ALU_Sel = 3'b000; Src_A = 2'd1; Src_B = 2'd1; IR_Load = 1'b1; CCR_Load = 1'b1; tick(); idle();
      #1;
      checks++; if (SP_out !== 8'hFD) begin errors++; $display("FAIL pre_reset_sp: got %h want FD", SP_out); end
      checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL pre_reset_err: got %b want 1", Stack_Err); end
      checks++; if (IR_out !== 8'hAA) begin errors++; $display("FAIL pre_reset_ir: got %h want AA", IR_out); end
      checks++; if (CCR_Result !== 4'b1010) begin errors++; $display("FAIL pre_reset_ccr: got %b want 1010", CCR_Result); end
      checks++; if (to_memory !== 8'h10) begin errors++; $display("FAIL pre_reset_pc: got %h want 10", to_memory); end

      do_reset(); idle(); #1;
      checks++; if (to_memory !== 8'h00) begin errors++; $display("FAIL midreset_pc: got %h want 00", to_memory); end
      Bus1_Sel = 2'b01; Src_A = 2'd1; #1;
      checks++; if (to_memory !== 8'h00) begin errors++; $display("FAIL midreset_r1: got %h want 00", to_memory); end
      checks++; if (SP_out !== 8'hFF) begin errors++; $display("FAIL midreset_sp: got %h want FF", SP_out); end
      checks++; if (CCR_Result !== 4'h0) begin errors++; $display("FAIL midreset_ccr: got %b want 0000", CCR_Result); end
      checks++; if (IR_out !== 8'h00) begin errors++; $display("FAIL midreset_ir: got %h want 00", IR_out); end
      checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b want 0", Stack_Err); end
      idle();
   endtask

   task automatic test_alu();
      // R0=7F, R1=01, R3=00
      logic [2:0] op_t [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
      logic [1:0] sa_t [9] = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
      logic [1:0] sb_t [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
      logic [7:0] res_t[9] = '{8'h80, 8'hFF, 8'h01, 8'h7F, 8'h00, 8'h80, 8'hFF, 8'h80, 8'h00};
      logic [3:0] ccr_t[9] = '{4'b1010, 4'b1001, 4'b0000, 4'b0000, 4'b0100,
                               4'b1010, 4'b1001, 4'b1000, 4'b0100};
      do_reset();
      load_reg(2'd0, 8'h7F);
      load_reg(2'd1, 8'h01);
      for (int i = 0; i < 9; i++) begin
         idle(); ALU_Sel = op_t[i]; Src_A = sa_t[i]; Src_B = sb_t[i];
         IR_Load = 1'b1; CCR_Load = 1'b1; tick(); idle();
         checks++; if (IR_out !== res_t[i]) begin errors++; $display("FAIL alu_res[%0d]: got %h want %h", i, IR_out, res_t[i]); end
         checks++; if (CCR_Result !== ccr_t[i]) begin errors++; $display("FAIL alu_ccr[%0d]: got %b want %b", i, CCR_Result, ccr_t[i]); end
      end

      // CCR holds without CCR_Load; latches flags even with Bus2 not on the ALU.
      ALU_Sel = 3'b000; Src_A = 2'd0; Src_B = 2'd1; tick(); idle();
      checks++; if (CCR_Result !== 4'b0100) begin errors++; $display("FAIL ccr_hold: got %b want 0100", CCR_Result); end
      ALU_Sel = 3'b000; Src_A = 2'd0; Src_B = 2'd1; Bus2_Sel = 2'b11; CCR_Load = 1'b1; IR_Load = 1'b1; tick(); idle();
      checks++; if (CCR_Result !== 4'b1010) begin errors++; $display("FAIL ccr_any_bus2: got %b want 1010", CCR_Result); end
      checks++; if (IR_out !== 8'h00) begin errors++; $display("FAIL bus2_zero: got %h want 00", IR_out); end

      // Read of the register being written returns the old value in that cycle.
      Bus2_Sel = 2'b10; from_memory = 8'h11; Dst = 2'd0; Reg_Load = 1'b1; Bus1_Sel = 2'b01; Src_A = 2'd0; #1;
      checks++; if (to_memory !== 8'h7F) begin errors++; $display("FAIL rf_no_bypass: got %h want 7F", to_memory); end
      tick(); #1;
      checks++; if (to_memory !== 8'h11) begin errors++; $display("FAIL rf_write: got %h want 11", to_memory); end
      idle();
   endtask

   task automatic test_pc_mar();
      do_reset();
      Bus2_Sel = 2'b10; from_memory = 8'hFF; PC_Load = 1'b1; tick(); idle(); #1;
      checks++; if (to_memory !== 8'hFF) begin errors++; $display("FAIL pc_load: got %h want FF", to_memory); end
      PC_Inc = 1'b1; tick(); idle(); #1;
      checks++; if (to_memory !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h want 00", to_memory); end
      checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL pc_wrap_err: got %b want 0", Stack_Err); end
      Bus2_Sel = 2'b10; from_memory = 8'h3C; PC_Load = 1'b1; PC_Inc = 1'b1; tick(); idle(); #1;
      checks++; if (to_memory !== 8'h3C) begin errors++; $display("FAIL pc_priority: got %h want 3C", to_memory); end
      PC_Inc = 1'b1; tick(); idle(); #1;
      checks++; if (to_memory !== 8'h3D) begin errors++; $display("FAIL pc_inc: got %h want 3D", to_memory); end
      Bus2_Sel = 2'b10; from_memory = 8'h42; MAR_Load = 1'b1; tick(); idle(); #1;
      checks++; if (address !== 8'h42) begin errors++; $display("FAIL mar_load: got %h want 42", address); end
      checks++; if (SP_out !== 8'hFF) begin errors++; $display("FAIL mar_sp_untouched: got %h want FF", SP_out); end
      Bus1_Sel = 2'b11; #1;
      checks++; if (to_memory !== 8'hFF) begin errors++; $display("FAIL bus1_sp: got %h want FF", to_memory); end
      idle();
   endtask

   task automatic test_push_pop();
      do_reset();
      load_reg(2'd2, 8'hA5);
      SP_Dec = 1'b1; tick(); idle(); #1;
      checks++; if (SP_out !== 8'hFE) begin errors++; $display("FAIL push_sp: got %h want FE", SP_out); end
      Addr_Sel = 1'b1; Bus1_Sel = 2'b01; Src_A = 2'd2; #1;
      checks++; if (address !== 8'hFE) begin errors++; $display("FAIL push_addr: got %h want FE", address); end
      checks++; if (to_memory !== 8'hA5) begin errors++; $display("FAIL push_data: got %h want A5", to_memory); end
      tick(); idle();
      Addr_Sel = 1'b1; Bus2_Sel = 2'b10; from_memory = 8'hA5; Dst = 2'd1; Reg_Load = 1'b1; tick(); idle();
      SP_Inc = 1'b1; tick(); idle(); #1;
      checks++; if (SP_out !== 8'hFF) begin errors++; $display("FAIL pop_sp: got %h want FF", SP_out); end
      checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL pop_err: got %b want 0", Stack_Err); end
      Bus1_Sel = 2'b10; Src_B = 2'd1; #1;
      checks++; if (to_memory !== 8'hA5) begin errors++; $display("FAIL pop_data: got %h want A5", to_memory); end
      idle();
   endtask

   task automatic test_stack_err();
      do_reset();
      SP_Inc = 1'b1; tick(); idle(); #1;
      checks++; if (SP_out !== 8'h00) begin errors++; $display("FAIL underflow_sp: got %h want 00", SP_out); end
      checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b want 1", Stack_Err); end
      tick(); #1;
      checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", Stack_Err); end
      Err_Clr = 1'b1; tick(); idle(); #1;
      checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", Stack_Err); end
      SP_Dec = 1'b1; Err_Clr = 1'b1; tick(); idle(); #1;
      checks++; if (Stack_Err !== 1'b1) begin errors++; $display("FAIL overflow_wins: got %b want 1", Stack_Err); end
      checks++; if (SP_out !== 8'hFF) begin errors++; $display("FAIL overflow_sp: got %h want FF", SP_out); end
      Err_Clr = 1'b1; tick(); idle();
      SP_Inc = 1'b1; SP_Dec = 1'b1; tick(); idle(); #1;
      checks++; if (SP_out !== 8'hFF) begin errors++; $display("FAIL incdec_sp: got %h want FF", SP_out); end
      checks++; if (Stack_Err !== 1'b0) begin errors++; $display("FAIL incdec_err: got %b want 0", Stack_Err); end
   endtask

   task automatic test_param();
      do_reset(); #1;
      checks++; if (sp_out_w !== 12'h0FF) begin errors++; $display("FAIL w_reset_sp: got %h want 0FF", sp_out_w); end
      load_reg_w(3'd7, 16'hFFFF);
      ALU_Sel = 3'b101; src_a_w = 3'd7; IR_Load = 1'b1; CCR_Load = 1'b1; tick(); idle(); #1;
      checks++; if (ir_out_w !== 16'h0000) begin errors++; $display("FAIL w_inc_res: got %h want 0000", ir_out_w); end
      checks++; if (ccr_w !== 4'b0101) begin errors++; $display("FAIL w_inc_ccr: got %b want 0101", ccr_w); end
      Bus2_Sel = 2'b10; from_memory_w = 16'hABCD; PC_Load = 1'b1; tick(); idle(); #1;
      checks++; if (to_memory_w !== 16'h0BCD) begin errors++; $display("FAIL w_pc_bus1: got %h want 0BCD", to_memory_w); end
      Bus2_Sel = 2'b10; from_memory_w = 16'h0FFF; PC_Load = 1'b1; tick(); idle();
      PC_Inc = 1'b1; tick(); idle(); #1;
      checks++; if (to_memory_w !== 16'h0000) begin errors++; $display("FAIL w_pc_wrap: got %h want 0000", to_memory_w); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0;
      idle();
      test_reset();
      test_alu();
      test_pc_mar();
      test_push_pop();
      test_stack_err();
      test_param();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
